// File: rtl/tag_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tag_uart_fifo
// Description : FIFO-buffered UART with Avalon-MM register slave, programmable
//               divisor, sticky error flags and maskable level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================

module tag_uart_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (c_aw+1)'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    // A full FIFO still accepts a push when an entry leaves in the same cycle.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_aw+1)'(1);
                2'b01:   r_level <= r_level - (c_aw+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

module tag_uart_fifo #(
    parameter int CLK_HZ       = 50000000,
    parameter int DEFAULT_BAUD = 115200,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq,
    input  logic        uart_RXD,
    output logic        uart_TXD
);
    localparam logic [15:0]       c_reset_div = 16'(CLK_HZ / DEFAULT_BAUD);
    localparam int                c_lw        = $clog2(FIFO_DEPTH) + 1;
    localparam int                c_bw        = $clog2(DATA_BITS);
    localparam logic [c_bw-1:0]   c_last_bit  = c_bw'(DATA_BITS - 1);
    localparam logic [1:0]        c_idle      = 2'd0;
    localparam logic [1:0]        c_start     = 2'd1;
    localparam logic [1:0]        c_data      = 2'd2;
    localparam logic [1:0]        c_stop      = 2'd3;

    logic w_data_wr, w_data_rd, w_div_wr, w_ctrl_wr;
    assign w_data_wr = avs_write && (avs_address == 2'd0);
    assign w_data_rd = avs_read  && (avs_address == 2'd0);
    assign w_div_wr  = avs_write && (avs_address == 2'd2);
    assign w_ctrl_wr = avs_write && (avs_address == 2'd3);

    logic w_unused;
    assign w_unused = ^avs_writedata[31:16];

    logic [15:0]          r_divisor;
    logic [1:0]           r_ctrl;
    logic                 r_overrun, r_framing, r_irq, r_txd;
    logic [31:0]          r_readdata, w_rd_data;

    logic [DATA_BITS-1:0] w_tx_head, w_rx_head;
    logic [c_lw-1:0]      w_tx_level, w_rx_level;
    logic                 w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic                 w_tx_pop, w_rx_push;

    // TX shifter state and next-state
    logic [1:0]           r_tx_state, w_tx_state_nx;
    logic [15:0]          r_tx_cnt, w_tx_cnt_nx, r_tx_div, w_tx_div_nx;
    logic [c_bw-1:0]      r_tx_bit, w_tx_bit_nx;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nx;
    logic                 w_txd_nx, w_tx_bit_end, w_tx_idle;

    // RX sampler state and next-state
    logic [1:0]           r_rx_sync;
    logic                 r_rx_prev;
    logic [1:0]           r_rx_state, w_rx_state_nx;
    logic [15:0]          r_rx_cnt, w_rx_cnt_nx, r_rx_div, w_rx_div_nx;
    logic [c_bw-1:0]      r_rx_bit, w_rx_bit_nx;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nx;
    logic                 w_rx_mid, w_rx_bit_end, w_overrun_set, w_framing_set;

    tag_uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk_clk), .rst(reset_reset), .i_push(w_data_wr), .i_pop(w_tx_pop),
        .i_din(avs_writedata[DATA_BITS-1:0]), .o_dout(w_tx_head),
        .o_level(w_tx_level), .o_empty(w_tx_empty), .o_full(w_tx_full)
    );

    tag_uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk_clk), .rst(reset_reset), .i_push(w_rx_push), .i_pop(w_data_rd),
        .i_din(r_rx_shift), .o_dout(w_rx_head),
        .o_level(w_rx_level), .o_empty(w_rx_empty), .o_full(w_rx_full)
    );

    assign w_tx_bit_end = (r_tx_cnt == r_tx_div - 16'd1);
    assign w_tx_idle    = (r_tx_state == c_idle) && w_tx_empty;

    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt + 16'd1;
        w_tx_div_nx   = r_tx_div;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_shift_nx = r_tx_shift;
        w_tx_pop      = 1'b0;
        case (r_tx_state)
            c_idle: begin
                w_tx_cnt_nx = '0;
                if (!w_tx_empty) begin
                    w_tx_pop      = 1'b1;
                    w_tx_shift_nx = w_tx_head;
                    w_tx_div_nx   = r_divisor;
                    w_tx_state_nx = c_start;
                end
            end
            c_start: if (w_tx_bit_end) begin
                w_tx_cnt_nx   = '0;
                w_tx_bit_nx   = '0;
                w_tx_state_nx = c_data;
            end
            c_data: if (w_tx_bit_end) begin
                w_tx_cnt_nx = '0;
                if (r_tx_bit == c_last_bit) begin
                    w_tx_state_nx = c_stop;
                end else begin
                    w_tx_bit_nx   = r_tx_bit + c_bw'(1);
                    w_tx_shift_nx = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                end
            end
            default: if (w_tx_bit_end) begin
                // Chain straight into the next start bit to avoid an idle gap.
                w_tx_cnt_nx = '0;
                if (!w_tx_empty) begin
                    w_tx_pop      = 1'b1;
                    w_tx_shift_nx = w_tx_head;
                    w_tx_div_nx   = r_divisor;
                    w_tx_state_nx = c_start;
                end else begin
                    w_tx_state_nx = c_idle;
                end
            end
        endcase
        w_txd_nx = (w_tx_state_nx == c_start) ? 1'b0 :
                   (w_tx_state_nx == c_data)  ? w_tx_shift_nx[0] : 1'b1;
    end

    assign w_rx_mid     = (r_rx_cnt == {1'b0, r_rx_div[15:1]} - 16'd1);
    assign w_rx_bit_end = (r_rx_cnt == r_rx_div - 16'd1);

    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt + 16'd1;
        w_rx_div_nx   = r_rx_div;
        w_rx_bit_nx   = r_rx_bit;
        w_rx_shift_nx = r_rx_shift;
        w_rx_push     = 1'b0;
        case (r_rx_state)
            c_idle: begin
                w_rx_cnt_nx = '0;
                if (r_rx_prev && !r_rx_sync[1]) begin
                    w_rx_div_nx   = r_divisor;
                    w_rx_state_nx = c_start;
                end
            end
            c_start: if (w_rx_mid) begin
                w_rx_cnt_nx   = '0;
                w_rx_bit_nx   = '0;
                w_rx_state_nx = r_rx_sync[1] ? c_idle : c_data;
            end
            c_data: if (w_rx_bit_end) begin
                w_rx_cnt_nx   = '0;
                w_rx_shift_nx = {r_rx_sync[1], r_rx_shift[DATA_BITS-1:1]};
                if (r_rx_bit == c_last_bit) w_rx_state_nx = c_stop;
                else                        w_rx_bit_nx   = r_rx_bit + c_bw'(1);
            end
            default: if (w_rx_bit_end) begin
                w_rx_cnt_nx   = '0;
                w_rx_push     = 1'b1;
                w_rx_state_nx = c_idle;
            end
        endcase
    end

    assign w_framing_set = w_rx_push & ~r_rx_sync[1];
    assign w_overrun_set = w_rx_push & w_rx_full & ~w_data_rd;

    always_comb begin
        w_rd_data = '0;
        case (avs_address)
            2'd0: if (!w_rx_empty) w_rd_data = {1'b1, {(31-DATA_BITS){1'b0}}, w_rx_head};
            2'd1: w_rd_data = {8'(w_tx_level), 8'(w_rx_level), 11'b0, r_framing, r_overrun,
                               w_tx_idle, ~w_tx_full, ~w_rx_empty};
            2'd2: w_rd_data = {16'b0, r_divisor};
            default: w_rd_data = {30'b0, r_ctrl};
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_divisor  <= c_reset_div;
            r_ctrl     <= '0;
            r_overrun  <= 1'b0;
            r_framing  <= 1'b0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
            r_txd      <= 1'b1;
            r_tx_state <= c_idle;
            r_tx_cnt   <= '0;
            r_tx_div   <= c_reset_div;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_rx_sync  <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_state <= c_idle;
            r_rx_cnt   <= '0;
            r_rx_div   <= c_reset_div;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            if (w_div_wr)
                r_divisor <= (avs_writedata[15:0] < 16'd4) ? 16'd4 : avs_writedata[15:0];
            if (w_ctrl_wr) r_ctrl <= avs_writedata[1:0];
            // A new error in the same cycle as its clear wins.
            if (w_ctrl_wr && avs_writedata[8]) r_overrun <= 1'b0;
            if (w_overrun_set)                  r_overrun <= 1'b1;
            if (w_ctrl_wr && avs_writedata[9]) r_framing <= 1'b0;
            if (w_framing_set)                  r_framing <= 1'b1;
            if (avs_read) r_readdata <= w_rd_data;
            r_irq      <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_empty);
            r_txd      <= w_txd_nx;
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_div   <= w_tx_div_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_rx_sync  <= {r_rx_sync[0], uart_RXD};
            r_rx_prev  <= r_rx_sync[1];
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_div   <= w_rx_div_nx;
            r_rx_bit   <= w_rx_bit_nx;
            r_rx_shift <= w_rx_shift_nx;
        end
    end

    assign avs_readdata = r_readdata;
    assign irq          = r_irq;
    assign uart_TXD     = r_txd;
endmodule

`default_nettype wire

// File: tb/tb_tag_uart_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tag_uart_fifo
// Description : Directed, table-driven bench for tag_uart_fifo (8 bits, depth 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tag_uart_fifo;
    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;
    logic        uart_RXD = 1'b1;
    logic        uart_TXD;

    tag_uart_fifo dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata), .irq(irq), .uart_RXD(uart_RXD), .uart_TXD(uart_TXD)
    );

    always #5 clk_clk = ~clk_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk_clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk_clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk_clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string name);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int div);
        uart_RXD = 1'b0;
        repeat (div) @(negedge clk_clk);
        for (int i = 0; i < 8; i++) begin
            uart_RXD = b[i];
            repeat (div) @(negedge clk_clk);
        end
        uart_RXD = stop_bit;
        repeat (div) @(negedge clk_clk);
        uart_RXD = 1'b1;
    endtask

    // Serial decoder on uart_TXD; divisor is taken at each start edge.
    logic       mon_en = 1'b0;
    int         mon_div = 434;
    int         mon_d;
    int         mon_bad_stop = 0;
    logic [7:0] mon_b;
    logic [7:0] mon_q[$];

    initial forever begin
        @(negedge uart_TXD);
        if (mon_en) begin
            mon_d = mon_div;
            repeat (mon_d / 2) @(negedge clk_clk);
            if (uart_TXD == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_d) @(negedge clk_clk);
                    mon_b[i] = uart_TXD;
                end
                repeat (mon_d) @(negedge clk_clk);
                if (uart_TXD !== 1'b1) mon_bad_stop++;
                mon_q.push_back(mon_b);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        string       name;
    } vec_t;

    vec_t        vecs[16];
    logic [9:0]  pat;
    logic [31:0] d;
    logic        done;

    initial begin
        vecs[0]  = '{1'b0, 2'd2, 32'h0000_01B2, "div_reset"};
        vecs[1]  = '{1'b0, 2'd1, 32'h0000_0006, "status_reset"};
        vecs[2]  = '{1'b0, 2'd3, 32'h0000_0000, "ctrl_reset"};
        vecs[3]  = '{1'b0, 2'd0, 32'h0000_0000, "data_empty"};
        vecs[4]  = '{1'b1, 2'd2, 32'h0000_0002, "w"};
        vecs[5]  = '{1'b0, 2'd2, 32'h0000_0004, "div_clamp2"};
        vecs[6]  = '{1'b1, 2'd2, 32'h0001_2345, "w"};
        vecs[7]  = '{1'b0, 2'd2, 32'h0000_2345, "div_16b"};
        vecs[8]  = '{1'b1, 2'd2, 32'h0000_0003, "w"};
        vecs[9]  = '{1'b0, 2'd2, 32'h0000_0004, "div_clamp3"};
        vecs[10] = '{1'b1, 2'd3, 32'hFFFF_FFFF, "w"};
        vecs[11] = '{1'b0, 2'd3, 32'h0000_0003, "ctrl_rw"};
        vecs[12] = '{1'b1, 2'd3, 32'h0000_0000, "w"};
        vecs[13] = '{1'b0, 2'd3, 32'h0000_0000, "ctrl_clear"};
        vecs[14] = '{1'b1, 2'd2, 32'h0000_0004, "w"};
        vecs[15] = '{1'b0, 2'd2, 32'h0000_0004, "div_4"};

        repeat (3) @(negedge clk_clk);
        check("txd_reset", {31'b0, uart_TXD}, 32'd1);
        check("irq_reset", {31'b0, irq}, 32'd0);
        check("rdata_reset", avs_readdata, 32'd0);
        reset_reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else            read_check(vecs[i].addr, vecs[i].data, vecs[i].name);
        end

        // TX timing at divisor 4: start, 0xA5 LSB first, stop
        pat = {1'b1, 8'hA5, 1'b0};
        bus_write(2'd0, 32'h0000_00A5);
        check("txd_before_start", {31'b0, uart_TXD}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_clk);
            check("tx_bit", {31'b0, uart_TXD}, {31'b0, pat[i/4]});
        end
        read_check(2'd1, 32'h0000_0006, "tx_idle_after_frame");

        // RX loopback at divisor 16
        bus_write(2'd2, 32'd16);
        send_byte(8'h00, 1'b1, 16);
        send_byte(8'hFF, 1'b1, 16);
        send_byte(8'h3C, 1'b1, 16);
        repeat (4) @(negedge clk_clk);
        read_check(2'd1, 32'h0003_0007, "rx_level3");
        read_check(2'd0, 32'h8000_0000, "rx_byte00");
        read_check(2'd0, 32'h8000_00FF, "rx_byteFF");
        read_check(2'd0, 32'h8000_003C, "rx_byte3C");
        read_check(2'd0, 32'h0000_0000, "rx_empty_read");

        // Overrun: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_byte(8'(8'h40 + i), 1'b1, 16);
        repeat (4) @(negedge clk_clk);
        read_check(2'd1, 32'h0010_000F, "overrun_status");
        read_check(2'd0, 32'h8000_0040, "overrun_first");
        bus_write(2'd3, 32'h0000_0100);
        read_check(2'd1, 32'h000F_0007, "overrun_clear");
        for (int i = 0; i < 15; i++) read_check(2'd0, 32'h8000_0041 + 32'(i), "overrun_drain");

        // Framing error then glitch rejection
        send_byte(8'h5A, 1'b0, 16);
        repeat (4) @(negedge clk_clk);
        read_check(2'd1, 32'h0001_0017, "framing_status");
        read_check(2'd0, 32'h8000_005A, "framing_byte");
        bus_write(2'd3, 32'h0000_0200);
        read_check(2'd1, 32'h0000_0006, "framing_clear");
        uart_RXD = 1'b0;
        repeat (3) @(negedge clk_clk);
        uart_RXD = 1'b1;
        repeat (20) @(negedge clk_clk);
        read_check(2'd1, 32'h0000_0006, "glitch_no_push");
        send_byte(8'h81, 1'b1, 16);
        repeat (4) @(negedge clk_clk);
        read_check(2'd0, 32'h8000_0081, "after_glitch_byte");

        // Interrupts
        check("irq_off", {31'b0, irq}, 32'd0);
        bus_write(2'd3, 32'd3);
        check("irq_lag", {31'b0, irq}, 32'd0);
        @(negedge clk_clk);
        check("irq_tx_empty", {31'b0, irq}, 32'd1);
        bus_write(2'd3, 32'd1);
        repeat (2) @(negedge clk_clk);
        check("irq_rx_none", {31'b0, irq}, 32'd0);
        send_byte(8'h77, 1'b1, 16);
        repeat (4) @(negedge clk_clk);
        check("irq_rx", {31'b0, irq}, 32'd1);
        read_check(2'd0, 32'h8000_0077, "irq_rx_byte");
        @(negedge clk_clk);
        check("irq_rx_cleared", {31'b0, irq}, 32'd0);
        bus_write(2'd3, 32'd0);

        // TX full at divisor 434: 18 writes, 17 accepted
        bus_write(2'd2, 32'd434);
        mon_div = 434;
        mon_en  = 1'b1;
        for (int i = 0; i < 18; i++) bus_write(2'd0, 32'h10 + 32'(i));
        read_check(2'd1, 32'h1000_0000, "tx_full_status");
        mon_div = 4;
        bus_write(2'd2, 32'd4);
        done = 1'b0;
        for (int k = 0; k < 5000 && !done; k++) begin
            bus_read(2'd1, d);
            if (d[2]) done = 1'b1;
        end
        check("tx_drain", {31'b0, done}, 32'd1);
        repeat (10) @(negedge clk_clk);
        check("tx_frames", 32'(mon_q.size()), 32'd17);
        for (int i = 0; i < 17; i++)
            if (i < mon_q.size()) check("tx_byte", {24'b0, mon_q[i]}, 32'h10 + 32'(i));
        check("tx_stop_bits", 32'(mon_bad_stop), 32'd0);
        mon_en = 1'b0;

        // Reset during data bit 3 of a 0x00 frame
        bus_write(2'd2, 32'd16);
        bus_write(2'd0, 32'h0000_0000);
        bus_write(2'd0, 32'h0000_0055);
        repeat (71) @(negedge clk_clk);
        check("txd_bit3_low", {31'b0, uart_TXD}, 32'd0);
        #1 reset_reset = 1'b1;
        #1 check("txd_async_high", {31'b0, uart_TXD}, 32'd1);
        repeat (2) @(negedge clk_clk);
        reset_reset = 1'b0;
        read_check(2'd2, 32'h0000_01B2, "div_after_reset");
        read_check(2'd1, 32'h0000_0006, "status_after_reset");
        read_check(2'd3, 32'h0000_0000, "ctrl_after_reset");
        check("irq_after_reset", {31'b0, irq}, 32'd0);
        bus_write(2'd2, 32'd2);
        read_check(2'd2, 32'h0000_0004, "div_clamp_after_reset");
        repeat (20) @(negedge clk_clk);
        check("txd_idle_after_reset", {31'b0, uart_TXD}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
